scan_controller: RTL

Time-multiplexed scan controller for the six-digit display path in the counter experiment. It drives the 3-bit `select` and the `en` of the digit selector, so one 4-bit code reaches the shared seven-segment decoder at a time. It lights the matching common-anode digit for a programmable on-time and inserts a dark gap before the next digit to suppress ghosting. A one-cycle `frame_done` pulse marks each completed pass over all digits.

---
 rtl/scan_pkg.sv | 29 ++
 rtl/scan_controller_if.sv | 30 +++
 rtl/phase_timer.sv | 27 ++
 rtl/scan_controller.sv | 111 +++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding, default constants and width helpers for the digit scanner
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SHOW = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam int DEF_NUM_DIG = 6;
    localparam int DEF_DIV     = 50000;
    localparam int DEF_GAP     = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Phase counter width: must hold both DIV-1 and GAP-1, never narrower than 1 bit.
    function automatic int cnt_width(input int div, input int gap);
        int m;
        m = (div > gap) ? div : gap;
        if (m < 2) m = 2;
        return clog2(m);
    endfunction

endpackage

// File: rtl/scan_controller_if.sv
// rtl/scan_controller_if.sv - scan enable in, digit select/anode drive out
// Ports: en (scan enable), select (digit index), sel_en (selector enable),
//        an (active-low anodes), frame_done (end-of-frame pulse).
interface scan_controller_if
    import scan_pkg::*;
#(
    parameter int NUM_DIG = DEF_NUM_DIG
) ();
    logic               en;
    logic [2:0]         select;
    logic               sel_en;
    logic [NUM_DIG-1:0] an;
    logic               frame_done;

    modport master (
        input  en,
        output select,
        output sel_en,
        output an,
        output frame_done
    );

    modport slave (
        output en,
        input  select,
        input  sel_en,
        input  an,
        input  frame_done
    );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - up-counter with synchronous clear and terminal-count flag
// Ports: clk, rst_n (async active-low), clr (sync clear to 0), tc_val (terminal value),
//        cnt (current count), tc (cnt equals tc_val).
module phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [CW-1:0] tc_val,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/scan_controller.sv
// rtl/scan_controller.sv - time-multiplexed digit scanner with lit time, dark gap and frame pulse
// Ports: clk, rst_n (async active-low), bus (scan_controller_if.master: en in;
//        select, sel_en, an, frame_done out). All outputs come straight from flops.
module scan_controller
    import scan_pkg::*;
#(
    parameter int NUM_DIG = DEF_NUM_DIG,
    parameter int DIV     = DEF_DIV,
    parameter int GAP     = DEF_GAP
) (
    input  logic clk,
    input  logic rst_n,
    scan_controller_if.master bus
);

    localparam int              CW     = cnt_width(DIV, GAP);
    localparam logic [2:0]      LAST   = 3'(NUM_DIG - 1);
    localparam logic [CW-1:0]   DIV_TC = CW'(DIV - 1);
    localparam logic [CW-1:0]   GAP_TC = (GAP > 0) ? CW'(GAP - 1) : '0;

    state_t             state_q, state_d;
    logic [2:0]         select_q, select_d;
    logic [CW-1:0]      cnt, cnt_d, tc_val;
    logic               tc, clr;
    logic [NUM_DIG-1:0] an_q, an_d;
    logic               sel_en_q, sel_en_d;
    logic               fd_q, fd_d;

    assign tc_val = (state_q == ST_GAP) ? GAP_TC : DIV_TC;

    phase_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .tc_val (tc_val),
        .cnt    (cnt),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            select_q <= '0;
            an_q     <= '1;
            sel_en_q <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            an_q     <= an_d;
            sel_en_q <= sel_en_d;
            fd_q     <= fd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        clr      = 1'b0;
        if (!bus.en) begin
            state_d  = ST_IDLE;
            select_d = '0;
            clr      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SHOW;
                    select_d = '0;
                    clr      = 1'b1;
                end
                ST_SHOW: begin
                    if (tc) begin
                        clr      = 1'b1;
                        select_d = (select_q == LAST) ? 3'd0 : select_q + 3'd1;
                        state_d  = (GAP > 0) ? ST_GAP : ST_SHOW;
                    end
                end
                ST_GAP: begin
                    if (tc) begin
                        clr     = 1'b1;
                        state_d = ST_SHOW;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    select_d = '0;
                    clr      = 1'b1;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so that the registered copies line up
    // with state_q/cnt/select_q in the same cycle.
    assign cnt_d = clr ? '0 : cnt + CW'(1);

    always_comb begin
        an_d     = '1;
        sel_en_d = (state_d != ST_IDLE);
        fd_d     = (state_d == ST_SHOW) && (cnt_d == DIV_TC) && (select_d == LAST);
        for (int i = 0; i < NUM_DIG; i++) begin
            an_d[i] = !((state_d == ST_SHOW) && (select_d == 3'(i)));
        end
    end

    assign bus.select     = select_q;
    assign bus.sel_en     = sel_en_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;

endmodule
